// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encoding, beat counter width and a
// behavioural round-robin pick usable by any arbiter in the codebase.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int MAX_BURST_LIMIT = 15;
    localparam int MAX_REQ_LIMIT   = 8;

    // Sized for the largest legal MAX_BURST so every instance can share it.
    localparam int CNT_W = $clog2(MAX_BURST_LIMIT + 1);

    // One-hot of the first set request at or after ptr, wrapping at n.
    function automatic logic [MAX_REQ_LIMIT-1:0] rr_pick(
        input logic [MAX_REQ_LIMIT-1:0] req,
        input logic [2:0]               ptr,
        input int                       n
    );
        logic [MAX_REQ_LIMIT-1:0] pick;
        logic                     found;
        int                       idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ_LIMIT; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker: rotate so ptr lands on bit 0, isolate the
// lowest set bit, rotate back. Purely combinational.
module rr_priority_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_first;

    always_comb begin
        w_rot    = N'({i_req, i_req} >> i_ptr);
        // Two's-complement trick keeps only the lowest set bit.
        w_first  = w_rot & (~w_rot + N'(1));
        o_onehot = N'(({w_first, w_first} << i_ptr) >> N);
        o_any    = |i_req;
        o_idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (o_onehot[i]) begin
                o_idx = PW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: grants one requester at a time onto a shared
// valid/ready datapath and caps each grant at MAX_BURST beats.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int SRC_W     = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       gnt,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_last,
    output logic [SRC_W-1:0]      res_src,
    input  logic                  res_ready,
    output logic                  busy
);

    arb_state_e       r_state;
    arb_state_e       w_next_state;
    logic [SRC_W-1:0] r_ptr;
    logic [SRC_W-1:0] r_src;
    logic [NREQ-1:0]  r_gnt;
    logic [CNT_W-1:0] r_beat_cnt;

    logic [NREQ-1:0]  w_pick_onehot;
    logic [SRC_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_sel_req;
    logic             w_sel_last;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_at_cap;
    logic             w_xfer;
    logic             w_release;
    logic [SRC_W-1:0] w_ptr_next;

    rr_priority_pick #(
        .N(NREQ)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_onehot(w_pick_onehot),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Output muxes: everything visible to the datapath follows the held grant,
    // and res_ready only feeds internal state.
    always_comb begin
        w_sel_req  = req[r_src];
        w_sel_last = req_last[r_src];
        w_sel_data = req_data[r_src*WIDTH +: WIDTH];
        w_at_cap   = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
        busy       = (r_state == GRANT);
        res_valid  = busy & w_sel_req;
        res_last   = res_valid & (w_sel_last | w_at_cap);
        res_data   = res_valid ? w_sel_data : '0;
        w_xfer     = res_valid & res_ready;
        w_release  = busy & ((w_xfer & res_last) | (~w_sel_req & res_ready));
        w_ptr_next = (r_src == SRC_W'(NREQ - 1)) ? '0 : r_src + SRC_W'(1);
    end

    assign gnt     = r_gnt;
    assign res_src = r_src;

    always_comb begin
        // NOTE: the default comes first so every path assigns the signal;
        // a missing branch would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pick_any) w_next_state = GRANT;
            GRANT:   if (w_release)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr      <= '0;
            r_src      <= '0;
            r_gnt      <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_gnt      <= w_pick_onehot;
                        r_src      <= w_pick_idx;
                        r_beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    // Releasing always forces a dead IDLE cycle before the next grant.
                    if (w_release) begin
                        r_gnt <= '0;
                        r_ptr <= w_ptr_next;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench for rr_burst_arbiter: queue-driven requesters, expected
// beats/grants pushed by the stimulus and checked by an independent monitor.
module tb_rr_burst_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int         src;
        logic [7:0] data;
        logic       last;
    } exp_beat_t;

    typedef struct {
        int src;
        int gap;
    } exp_gnt_t;

    logic                  CLK;
    logic                  RST;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       gnt;
    logic                  res_valid;
    logic [WIDTH-1:0]      res_data;
    logic                  res_last;
    logic [1:0]            res_src;
    logic                  res_ready;
    logic                  busy;

    beat_t     src_q[NREQ][$];
    exp_beat_t exp_beat_q[$];
    exp_gnt_t  exp_gnt_q[$];

    int chk_cnt       = 0;
    int pass_cnt      = 0;
    int neg_cyc       = 0;
    int last_xfer_neg = 0;
    int fall_neg      = 0;

    rr_burst_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_last (res_last),
        .res_src  (res_src),
        .res_ready(res_ready),
        .busy     (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_beat(input int s, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[s].push_back(b);
    endtask

    task automatic exp_beat(input int s, input logic [7:0] d, input logic l);
        exp_beat_t e;
        e.src  = s;
        e.data = d;
        e.last = l;
        exp_beat_q.push_back(e);
    endtask

    task automatic exp_gnt(input int s, input int gap);
        exp_gnt_t e;
        e.src = s;
        e.gap = gap;
        exp_gnt_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_beat_q.size() != 0 || exp_gnt_q.size() != 0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(n < 200), 32'd1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (gnt == '0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(n < 50), 32'd1);
    endtask

    // Requester model: presents the head of its queue, pops on a completed transfer.
    initial begin : bfm
        bit x;
        int s;
        req      = '0;
        req_data = '0;
        req_last = '0;
        forever begin
            @(negedge CLK);
            x = res_valid && res_ready && !RST;
            s = int'(res_src);
            @(posedge CLK);
            #1;
            if (x && src_q[s].size() > 0) void'(src_q[s].pop_front());
            for (int i = 0; i < NREQ; i++) begin
                if (src_q[i].size() > 0) begin
                    req[i]                     = 1'b1;
                    req_data[i*WIDTH +: WIDTH] = src_q[i][0].data;
                    req_last[i]                = src_q[i][0].last;
                end else begin
                    req[i]                     = 1'b0;
                    req_data[i*WIDTH +: WIDTH] = '0;
                    req_last[i]                = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        logic [NREQ-1:0] prev_gnt;
        logic            prev_valid;
        logic            prev_ready;
        logic            prev_last;
        logic [7:0]      prev_data;
        int              idle_run;
        exp_beat_t       eb;
        exp_gnt_t        eg;
        prev_gnt   = '0;
        prev_valid = 1'b0;
        prev_ready = 1'b1;
        prev_last  = 1'b0;
        prev_data  = '0;
        idle_run   = 0;
        forever begin
            @(negedge CLK);
            neg_cyc++;
            if (!RST) begin
                if (res_valid && res_ready) begin
                    last_xfer_neg = neg_cyc;
                    check("beat_pending", 32'(exp_beat_q.size() > 0), 32'd1);
                    if (exp_beat_q.size() > 0) begin
                        eb = exp_beat_q.pop_front();
                        check("beat_src", 32'(res_src), 32'(eb.src));
                        check("beat_data", 32'(res_data), 32'(eb.data));
                        check("beat_last", 32'(res_last), 32'(eb.last));
                    end
                end
                if (prev_valid && !prev_ready) begin
                    check("stall_valid", 32'(res_valid), 32'd1);
                    check("stall_data", 32'(res_data), 32'(prev_data));
                    check("stall_last", 32'(res_last), 32'(prev_last));
                end
            end
            if (gnt != '0 && prev_gnt == '0) begin
                check("gnt_pending", 32'(exp_gnt_q.size() > 0), 32'd1);
                if (exp_gnt_q.size() > 0) begin
                    eg = exp_gnt_q.pop_front();
                    check("gnt_onehot", 32'(gnt), 32'(1) << eg.src);
                    check("gnt_res_src", 32'(res_src), 32'(eg.src));
                    check("gnt_busy", 32'(busy), 32'd1);
                    if (eg.gap >= 0) check("gnt_gap", 32'(idle_run), 32'(eg.gap));
                end
            end else if (gnt != '0) begin
                check("gnt_hold", 32'(gnt), 32'(prev_gnt));
            end
            if (gnt == '0 && prev_gnt != '0) fall_neg = neg_cyc;
            idle_run   = (gnt == '0) ? idle_run + 1 : 0;
            prev_gnt   = gnt;
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_last  = res_last;
            prev_data  = res_data;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not complete, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        RST       = 1'b1;
        res_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_last", 32'(res_last), 32'd0);
        check("rst_src", 32'(res_src), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Single requester 1: AA, BB, CC(last); one-cycle arbitration latency.
        @(negedge CLK);
        exp_gnt(1, -1);
        exp_beat(1, 8'hAA, 1'b0);
        exp_beat(1, 8'hBB, 1'b0);
        exp_beat(1, 8'hCC, 1'b1);
        push_beat(1, 8'hAA, 1'b0);
        push_beat(1, 8'hBB, 1'b0);
        push_beat(1, 8'hCC, 1'b1);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("lat_gnt", 32'(gnt), 32'h2);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_valid", 32'(res_valid), 32'd1);
        check("lat_src", 32'(res_src), 32'd1);
        check("lat_data", 32'(res_data), 32'hAA);
        wait_drain("single_drain");
        check("single_release_lag", 32'(fall_neg - last_xfer_neg), 32'd1);
        check("single_idle_busy", 32'(busy), 32'd0);

        // ptr is now 2: simultaneous 0/2/3 resolve as 2, 3, 0.
        exp_gnt(2, -1);
        exp_gnt(3, 1);
        exp_gnt(0, 1);
        exp_beat(2, 8'h2B, 1'b1);
        exp_beat(3, 8'h3B, 1'b1);
        exp_beat(0, 8'h0B, 1'b1);
        push_beat(0, 8'h0B, 1'b1);
        push_beat(2, 8'h2B, 1'b1);
        push_beat(3, 8'h3B, 1'b1);
        wait_drain("ptr_drain");

        // Fairness: all four held, single-beat bursts; ptr starts at 1.
        for (int i = 0; i < NREQ; i++) begin
            push_beat(i, 8'hF0 + 8'(i), 1'b1);
            push_beat(i, 8'hE0 + 8'(i), 1'b1);
        end
        exp_gnt(1, -1);
        exp_beat(1, 8'hF1, 1'b1);
        exp_gnt(2, 1);
        exp_beat(2, 8'hF2, 1'b1);
        exp_gnt(3, 1);
        exp_beat(3, 8'hF3, 1'b1);
        exp_gnt(0, 1);
        exp_beat(0, 8'hF0, 1'b1);
        exp_gnt(1, 1);
        exp_beat(1, 8'hE1, 1'b1);
        exp_gnt(2, 1);
        exp_beat(2, 8'hE2, 1'b1);
        exp_gnt(3, 1);
        exp_beat(3, 8'hE3, 1'b1);
        exp_gnt(0, 1);
        exp_beat(0, 8'hE0, 1'b1);
        wait_drain("fair_drain");

        // Burst cap: requester 0 sends 6 beats without last, requester 1 waits.
        exp_gnt(0, -1);
        exp_gnt(1, 1);
        exp_gnt(0, 1);
        for (int i = 1; i <= 6; i++) push_beat(0, 8'(i), 1'b0);
        exp_beat(0, 8'h01, 1'b0);
        exp_beat(0, 8'h02, 1'b0);
        exp_beat(0, 8'h03, 1'b0);
        exp_beat(0, 8'h04, 1'b1);
        exp_beat(1, 8'h11, 1'b1);
        exp_beat(0, 8'h05, 1'b0);
        exp_beat(0, 8'h06, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        push_beat(1, 8'h11, 1'b1);
        wait_drain("cap_drain");

        // Backpressure: ready low for 5 cycles after the first beat of requester 2.
        exp_gnt(2, -1);
        exp_beat(2, 8'h21, 1'b0);
        exp_beat(2, 8'h22, 1'b0);
        exp_beat(2, 8'h23, 1'b0);
        exp_beat(2, 8'h24, 1'b1);
        push_beat(2, 8'h21, 1'b0);
        push_beat(2, 8'h22, 1'b0);
        push_beat(2, 8'h23, 1'b0);
        push_beat(2, 8'h24, 1'b1);
        wait_grant("bp_grant");
        @(posedge CLK);
        #1 res_ready = 1'b0;
        repeat (5) @(posedge CLK);
        #1 res_ready = 1'b1;
        wait_drain("bp_drain");

        // Abandon: requester 3 runs dry mid-burst; ptr must move past it to 0.
        exp_gnt(3, -1);
        exp_beat(3, 8'h31, 1'b0);
        exp_beat(3, 8'h32, 1'b0);
        push_beat(3, 8'h31, 1'b0);
        push_beat(3, 8'h32, 1'b0);
        wait_drain("abandon_drain");
        check("abandon_release_lag", 32'(fall_neg - last_xfer_neg), 32'd2);
        check("abandon_gnt_idle", 32'(gnt), 32'd0);
        exp_gnt(0, -1);
        exp_gnt(3, 1);
        exp_beat(0, 8'h0A, 1'b1);
        exp_beat(3, 8'h3A, 1'b1);
        push_beat(0, 8'h0A, 1'b1);
        push_beat(3, 8'h3A, 1'b1);
        wait_drain("abandon_next_drain");

        // Move ptr to 3 so the reset test can show it returning to 0.
        exp_gnt(2, -1);
        exp_beat(2, 8'h60, 1'b1);
        push_beat(2, 8'h60, 1'b1);
        wait_drain("preset_drain");

        // Reset during beat 2 of 4 from requester 1.
        exp_gnt(1, -1);
        exp_beat(1, 8'h41, 1'b0);
        push_beat(1, 8'h41, 1'b0);
        push_beat(1, 8'h42, 1'b0);
        push_beat(1, 8'h43, 1'b0);
        push_beat(1, 8'h44, 1'b1);
        wait_grant("rst_mid_grant");
        @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        src_q[1].delete();
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_gnt", 32'(gnt), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(res_valid), 32'd0);
        check("rst_mid_src", 32'(res_src), 32'd0);
        exp_gnt(1, -1);
        exp_gnt(3, 1);
        exp_beat(1, 8'h45, 1'b1);
        exp_beat(3, 8'h55, 1'b1);
        push_beat(1, 8'h45, 1'b1);
        push_beat(3, 8'h55, 1'b1);
        wait_drain("post_rst_drain");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
